// File: rtl/score4_move_ctrl.sv
// Turn sequencer for score-4: cursor, per-column fill heights, player turn, gravity drop, write, win wait.
// Latency: put -> wr_en after (landing+1)*DROP_TICKS+1 cycles; verdict CHECK_CYCLES cycles after wr_en.
// Backpressure: none; left/right/put pulses arriving outside SELECT (or after game over) are discarded.
//
// Optional feature macro: SCORE4_TURN_TIMER_EN (idle turn timer; forces a turn pass after TURN_TIMEOUT
// idle SELECT cycles and pulses timeout). Without it, timeout is tied low and no counter exists.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   left/right/put     single-cycle synchronized command pulses
//   win_a_i/win_b_i    win checker verdicts, sampled CHECK_CYCLES cycles after wr_en
//   cursor_col         selected column          player       side to move (0=A, 1=B)
//   drop_active        falling token shown      drop_row     row of the falling token
//   wr_en/wr_row/wr_col/wr_player   one-cycle panel write; row/col/player hold between writes
//   invalid_move       last put hit a full column
//   full_panel         every cell occupied      game_over    terminal state reached
//   timeout            one-cycle pulse on a forced turn pass

module score4_move_ctrl #(
  parameter int ROWS         = 6,
  parameter int COLS         = 7,
  parameter int DROP_TICKS   = 4,
  parameter int CHECK_CYCLES = 2
`ifdef SCORE4_TURN_TIMER_EN
  ,
  parameter int TURN_TIMEOUT = 255
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  input  logic       win_a_i,
  input  logic       win_b_i,
  output logic [2:0] cursor_col,
  output logic       player,
  output logic       drop_active,
  output logic [2:0] drop_row,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic       wr_player,
  output logic       invalid_move,
  output logic       full_panel,
  output logic       game_over,
  output logic       timeout
);

  localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam int CW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DROP_TICKS - 1);
  localparam logic [CW-1:0] CHK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [2:0]    ROWS_V    = 3'(ROWS);
  localparam logic [2:0]    LAND_MAX  = 3'(ROWS - 1);
  localparam logic [2:0]    COL_MAX   = 3'(COLS - 1);
  localparam logic [5:0]    CELLS     = 6'(ROWS * COLS);

  typedef enum logic [2:0] {
    S_SELECT,
    S_DROP,
    S_WRITE,
    S_CHECK,
    S_OVER
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    height [COLS];
  logic [2:0]    tgt_col;
  logic [2:0]    land_row;
  logic [TW-1:0] tick;
  logic [CW-1:0] chk_cnt;
  logic [5:0]    move_cnt;

  logic [2:0] cur_height;
  logic       in_select;
  logic       col_full;
  logic       put_ok;
  logic       put_bad;
  logic       mv_left;
  logic       mv_right;
  logic       drop_last;
  logic       chk_last;
  logic       panel_full;
  logic       game_end;
  logic       timer_fire;
  logic       player_flip;

  // Command decode; everything is qualified by SELECT so pulses elsewhere are simply lost.
  assign in_select  = (state == S_SELECT);
  assign cur_height = height[cursor_col];
  assign col_full   = (cur_height >= ROWS_V);
  assign put_ok     = in_select & put & ~col_full;
  assign put_bad    = in_select & put & col_full;
  // put wins over left/right; left+right together cancel out completely.
  assign mv_left    = in_select & ~put & left & ~right;
  assign mv_right   = in_select & ~put & right & ~left;

  // Last tick of the landing row ends the animation.
  assign drop_last  = (state == S_DROP) && (tick == TICK_LAST) && (drop_row == land_row);
  assign chk_last   = (state == S_CHECK) && (chk_cnt == CHK_LAST);
  assign panel_full = (move_cnt == CELLS);
  assign game_end   = win_a_i | win_b_i | panel_full;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_SELECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    drop_active = 1'b0;
    case (state)
      S_SELECT: begin
        if (put_ok) state_nxt = S_DROP;
      end
      S_DROP: begin
        drop_active = 1'b1;
        if (drop_last) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (chk_last) state_nxt = game_end ? S_OVER : S_SELECT;
      end
      S_OVER: begin
        state_nxt = S_OVER;
      end
      default: begin
        state_nxt = S_SELECT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cursor and invalid-move flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_col   <= 3'd0;
      invalid_move <= 1'b0;
    end else begin
      if (mv_left) begin
        cursor_col <= (cursor_col == 3'd0) ? COL_MAX : cursor_col - 3'd1;
      end else if (mv_right) begin
        cursor_col <= (cursor_col == COL_MAX) ? 3'd0 : cursor_col + 3'd1;
      end

      if (put_bad) begin
        invalid_move <= 1'b1;
      end else if (put_ok || mv_left || mv_right) begin
        invalid_move <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop animation and panel write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_col   <= 3'd0;
      land_row  <= 3'd0;
      drop_row  <= 3'd0;
      tick      <= '0;
      wr_en     <= 1'b0;
      wr_row    <= 3'd0;
      wr_col    <= 3'd0;
      wr_player <= 1'b0;
    end else begin
      wr_en <= drop_last;

      if (put_ok) begin
        tgt_col  <= cursor_col;
        land_row <= LAND_MAX - cur_height;
        drop_row <= 3'd0;
        tick     <= '0;
      end else if (state == S_DROP) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          if (drop_row != land_row) drop_row <= drop_row + 3'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end else if (state == S_WRITE) begin
        drop_row <= 3'd0;
      end

      // wr_* are registered alongside wr_en so they stay stable until the next write.
      if (drop_last) begin
        wr_row    <= land_row;
        wr_col    <= tgt_col;
        wr_player <= player;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Column heights and move count (committed in the write cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) height[i] <= 3'd0;
      move_cnt <= 6'd0;
    end else if (state == S_WRITE) begin
      height[tgt_col] <= height[tgt_col] + 3'd1;
      move_cnt        <= move_cnt + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Win check window and game result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_cnt    <= '0;
      game_over  <= 1'b0;
      full_panel <= 1'b0;
    end else begin
      if (state == S_WRITE) begin
        chk_cnt <= '0;
      end else if ((state == S_CHECK) && !chk_last) begin
        chk_cnt <= chk_cnt + 1'b1;
      end

      if (chk_last && game_end) begin
        game_over  <= 1'b1;
        full_panel <= panel_full;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional idle turn timer
  // ---------------------------------------------------------------------------
`ifdef SCORE4_TURN_TIMER_EN
  logic [15:0] idle_cnt;
  logic        any_cmd;

  assign any_cmd    = left | right | put;
  assign timer_fire = in_select && !any_cmd && (idle_cnt == 16'(TURN_TIMEOUT - 1));

  // Counter only moves in SELECT, so it is effectively frozen during drop/check/over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timer_fire;
      if (in_select) begin
        if (any_cmd || timer_fire) begin
          idle_cnt <= 16'd0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign timer_fire = 1'b0;
  assign timeout    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Turn ownership; frozen once the game is over
  // ---------------------------------------------------------------------------
  assign player_flip = (chk_last & ~game_end) | timer_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player <= 1'b0;
    end else if (player_flip) begin
      player <= ~player;
    end
  end

endmodule

// File: tb/tb_score4_move_ctrl.sv
module tb_score4_move_ctrl;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int DT   = 4;
  localparam int CC   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       left = 1'b0, right = 1'b0, put = 1'b0;
  logic       win_a = 1'b0, win_b = 1'b0;
  logic [2:0] cursor_col, drop_row, wr_row, wr_col;
  logic       player, drop_active, wr_en, wr_player;
  logic       invalid_move, full_panel, game_over, timeout;

  always #5 clk = ~clk;

  score4_move_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DROP_TICKS(DT), .CHECK_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .win_a_i(win_a), .win_b_i(win_b),
    .cursor_col(cursor_col), .player(player), .drop_active(drop_active),
    .drop_row(drop_row), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_player(wr_player), .invalid_move(invalid_move), .full_panel(full_panel),
    .game_over(game_over), .timeout(timeout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the board as column fill counts plus turn bookkeeping.
  int m_h [COLS];
  int m_cur, m_player, m_moves;
  bit m_over, m_full, m_inv;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) m_h[i] = 0;
    m_cur = 0; m_player = 0; m_moves = 0;
    m_over = 0; m_full = 0; m_inv = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cursor"}, cursor_col, m_cur);
    check({tag, ".player"}, player, m_player);
    check({tag, ".invalid"}, invalid_move, m_inv);
    check({tag, ".game_over"}, game_over, m_over);
    check({tag, ".full"}, full_panel, m_full);
    check({tag, ".drop_active"}, drop_active, 0);
    check({tag, ".wr_en"}, wr_en, 0);
`ifndef SCORE4_TURN_TIMER_EN
    check({tag, ".timeout"}, timeout, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cursor"}, cursor_col, 0);
    check({tag, ".player"}, player, 0);
    check({tag, ".drop_active"}, drop_active, 0);
    check({tag, ".drop_row"}, drop_row, 0);
    check({tag, ".wr_en"}, wr_en, 0);
    check({tag, ".wr_row"}, wr_row, 0);
    check({tag, ".wr_col"}, wr_col, 0);
    check({tag, ".wr_player"}, wr_player, 0);
    check({tag, ".invalid"}, invalid_move, 0);
    check({tag, ".full"}, full_panel, 0);
    check({tag, ".game_over"}, game_over, 0);
    check({tag, ".timeout"}, timeout, 0);
  endtask

  task automatic do_reset();
    left = 0; right = 0; put = 0; win_a = 0; win_b = 0;
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    tick_clk();
    tick_clk();
    rst = 1'b1;
    tick_clk();
    model_reset();
  endtask

  task automatic do_lr(input bit l, input bit r);
    left = l; right = r;
    tick_clk();
    left = 0; right = 0;
    if (!m_over) begin
      if (l && !r) begin
        m_cur = (m_cur == 0) ? COLS - 1 : m_cur - 1;
        m_inv = 0;
      end else if (r && !l) begin
        m_cur = (m_cur == COLS - 1) ? 0 : m_cur + 1;
        m_inv = 0;
      end
    end
    check_state("lr");
  endtask

  task automatic move_to(input int c);
    for (int i = 0; i < COLS && m_cur != c; i++) do_lr(1'b0, 1'b1);
  endtask

  // Silence check: no write and no animation over n cycles.
  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick_clk();
      seen += int'(wr_en) + int'(drop_active);
    end
    check(tag, seen, 0);
  endtask

  task automatic do_put(input bit wa, input bit wb);
    int land, exp_len, k, bad;
    put = 1;
    tick_clk();
    put = 0;
    if (m_over) begin
      check_state("put_over");
      expect_quiet("put_over.quiet", DT * ROWS + 4);
      return;
    end
    if (m_h[m_cur] == ROWS) begin
      m_inv = 1;
      check_state("put_full");
      expect_quiet("put_full.quiet", DT + 4);
      return;
    end
    m_inv   = 0;
    land    = ROWS - 1 - m_h[m_cur];
    exp_len = (land + 1) * DT;
    k = 0; bad = 0;
    while (!wr_en && k < 200) begin
      if (drop_active !== 1'b1 || int'(drop_row) != k / DT) bad++;
      // Commands during the drop must be discarded.
      left  = 1'($urandom_range(0, 1));
      right = 1'($urandom_range(0, 1));
      put   = 1'($urandom_range(0, 1));
      tick_clk();
      left = 0; right = 0; put = 0;
      k++;
    end
    check("drop.len", k, exp_len);
    check("drop.row_trace", bad, 0);
    check("write.wr_en", wr_en, 1);
    check("write.row", wr_row, land);
    check("write.col", wr_col, m_cur);
    check("write.player", wr_player, m_player);
    check("write.drop_active", drop_active, 0);
    check("write.cursor", cursor_col, m_cur);
    m_h[m_cur]++;
    m_moves++;
    for (int i = 0; i < CC; i++) begin
      tick_clk();
      check("check.wr_en", wr_en, 0);
      check("check.game_over", game_over, 0);
      check("check.player", player, m_player);
    end
    win_a = wa; win_b = wb;
    tick_clk();
    win_a = 0; win_b = 0;
    if (wa || wb || m_moves == ROWS * COLS) begin
      m_over = 1;
      m_full = (m_moves == ROWS * COLS);
    end else begin
      m_player ^= 1;
    end
    check_state("verdict");
    check("verdict.wr_row_hold", wr_row, land);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cursor wrap and cancellation
    do_reset();
    do_lr(1'b1, 1'b0);
    check("wrap_left", cursor_col, COLS - 1);
    do_lr(1'b0, 1'b1);
    do_lr(1'b0, 1'b1);
    check("wrap_right", cursor_col, 1);
    do_lr(1'b1, 1'b1);
    check("lr_cancel", cursor_col, 1);

    // Single drop in column 0
    do_reset();
    do_put(1'b0, 1'b0);
    check("first_turn_pass", player, 1);

    // Fill the whole panel with no win; column 0 overflow exercises invalid_move
    do_reset();
    for (int c = 0; c < COLS; c++) begin
      move_to(c);
      for (int r = 0; r < ROWS; r++) do_put(1'b0, 1'b0);
      if (c == 0) begin
        do_put(1'b0, 1'b0);
        check("overflow.invalid", invalid_move, 1);
        do_lr(1'b0, 1'b1);
        check("overflow.cleared", invalid_move, 0);
        move_to(0);
      end
    end
    check("fill.full", full_panel, 1);
    check("fill.over", game_over, 1);
    do_put(1'b0, 1'b0);
    do_lr(1'b1, 1'b0);

    // Forced win for player A on the first move
    do_reset();
    do_put(1'b1, 1'b0);
    check("win_a.over", game_over, 1);
    check("win_a.player", player, 0);
    do_put(1'b0, 1'b0);

    // Randomized games
    for (int g = 0; g < 18; g++) begin
      do_reset();
      for (int s = 0; s < 120 && !m_over; s++) begin
        case ($urandom_range(0, 5))
          0: do_lr(1'b1, 1'b0);
          1: do_lr(1'b0, 1'b1);
          2: do_lr(1'b1, 1'b1);
          default: do_put(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0));
        endcase
        repeat ($urandom_range(0, 2)) tick_clk();
      end
      do_put(1'b0, 1'b0);
      do_lr(1'b0, 1'b1);
    end

    // Reset in the middle of a drop aborts it
    do_reset();
    do_lr(1'b0, 1'b1);
    put = 1;
    tick_clk();
    put = 0;
    repeat (5) tick_clk();
    check("middrop.active", drop_active, 1);
    rst = 1'b0;
    #1;
    check_all_zero("middrop");
    tick_clk();
    rst = 1'b1;
    model_reset();
    expect_quiet("middrop.quiet", DT * ROWS + 8);
    check_state("middrop.after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
